// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared FSM state type and debounce defaults for word_input_capture.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  // 10 ms of stability at 27 MHz
  localparam int DEBOUNCE_DEFAULT = 270000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - DEPTH-stage flop chain bringing an asynchronous bus into the clk domain.
module sync_ff #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/word_input_capture.sv
// rtl/word_input_capture.sv - debounced push-button that latches a data word and error mask per press.
module word_input_capture
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic [3:0] sw_data,
  input  logic [6:0] sw_err,
  output logic       btn_level,
  output logic       btn_press,
  output logic [3:0] data_q,
  output logic [6:0] err_q,
  output logic       valid
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic       btn_s;
  logic [3:0] data_s;
  logic [6:0] err_s;

  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_btn (
    .clk(clk), .rst_n(rst_n), .d(btn_raw), .q(btn_s)
  );
  sync_ff #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(sw_data), .q(data_s)
  );
  sync_ff #(.WIDTH(7), .DEPTH(SYNC_STAGES)) u_sync_err (
    .clk(clk), .rst_n(rst_n), .d(sw_err), .q(err_s)
  );

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          accept;
  logic          level_nxt;

  // Saturating increment keeps the counter from wrapping back into a short count
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARM_PRESS;
          cnt_nxt   = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = ARM_RELEASE;
          cnt_nxt   = '0;
        end
      end
      ARM_RELEASE: begin
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == HELD) || (state_nxt == ARM_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      valid     <= 1'b0;
      data_q    <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_press <= accept;
      valid     <= valid | accept;
      if (accept) begin
        data_q <= data_s;
        err_q  <= err_s;
      end
    end
  end

endmodule

// File: tb/tb_word_input_capture.sv
// tb/tb_word_input_capture.sv - randomized self-checking bench for word_input_capture.
module tb_word_input_capture;

  localparam int D = 8;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic [3:0] sw_data = '0;
  logic [6:0] sw_err = '0;
  logic       btn_level, btn_press, valid;
  logic [3:0] data_q;
  logic [6:0] err_q;

  word_input_capture #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_data(sw_data), .sw_err(sw_err),
    .btn_level(btn_level), .btn_press(btn_press), .data_q(data_q), .err_q(err_q), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int dut_presses = 0;
  bit mon_en = 1'b0;

  // Reference: inputs delayed S cycles; level flips after D+1 consecutive disagreeing samples
  logic [S-1:0] m_sb = '0;
  logic [3:0]   m_sd [S];
  logic [6:0]   m_se [S];
  logic         m_lvl = 1'b0, m_press = 1'b0, m_valid = 1'b0;
  logic [3:0]   m_data = '0;
  logic [6:0]   m_err = '0;
  int           m_run = 0;

  task automatic tick();
    logic s;
    logic [3:0] sd;
    logic [6:0] se;
    @(posedge clk);
    if (!rst_n) begin
      m_sb = '0;
      for (int i = 0; i < S; i++) begin m_sd[i] = '0; m_se[i] = '0; end
      m_lvl = 0; m_run = 0; m_press = 0; m_valid = 0; m_data = '0; m_err = '0;
    end else begin
      s = m_sb[S-1]; sd = m_sd[S-1]; se = m_se[S-1];
      m_press = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = s;
          m_run = 0;
          if (s) begin m_press = 1; m_valid = 1; m_data = sd; m_err = se; end
        end
      end else begin
        m_run = 0;
      end
      for (int i = S - 1; i > 0; i--) begin
        m_sb[i] = m_sb[i-1]; m_sd[i] = m_sd[i-1]; m_se[i] = m_se[i-1];
      end
      m_sb[0] = btn_raw; m_sd[0] = sw_data; m_se[0] = sw_err;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (btn_level !== m_lvl) begin n_fail++; $display("FAIL mon_btn_level t=%0t got=%b exp=%b", $time, btn_level, m_lvl); end
      n_checks++;
      if (btn_press !== m_press) begin n_fail++; $display("FAIL mon_btn_press t=%0t got=%b exp=%b", $time, btn_press, m_press); end
      n_checks++;
      if (valid !== m_valid) begin n_fail++; $display("FAIL mon_valid t=%0t got=%b exp=%b", $time, valid, m_valid); end
      n_checks++;
      if (data_q !== m_data) begin n_fail++; $display("FAIL mon_data_q t=%0t got=%h exp=%h", $time, data_q, m_data); end
      n_checks++;
      if (err_q !== m_err) begin n_fail++; $display("FAIL mon_err_q t=%0t got=%h exp=%h", $time, err_q, m_err); end
      if (btn_press === 1'b1) dut_presses++;
    end
  end

  task automatic test_reset();
    int lat;
    bit found;
    int p0;
    rst_n = 0; btn_raw = 1; sw_data = 4'h5; sw_err = 7'h55;
    tick();
    mon_en = 1;
    repeat (3) tick();
    n_checks++;
    if ({btn_level, btn_press, valid, data_q, err_q} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", {btn_level, btn_press, valid, data_q, err_q});
    end
    p0 = dut_presses;
    rst_n = 1;
    lat = 0; found = 0;
    for (int i = 0; i < S + D + 10 && !found; i++) begin
      tick();
      lat++;
      if (btn_press === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL reset_held_press got=none exp=one press"); end
    n_checks++;
    if (lat < S + D || lat > S + D + 2) begin n_fail++; $display("FAIL reset_latency got=%0d exp=%0d+/-1", lat, S + D + 1); end
    repeat (5) tick();
    n_checks++;
    if (dut_presses - p0 != 1) begin n_fail++; $display("FAIL reset_press_count got=%0d exp=1", dut_presses - p0); end
    n_checks++;
    if (data_q !== 4'h5 || err_q !== 7'h55) begin n_fail++; $display("FAIL reset_latch got=%h/%h exp=5/55", data_q, err_q); end
    btn_raw = 0;
    repeat (S + D + 4) tick();
    n_checks++;
    if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_release_level got=%b exp=0", btn_level); end
  endtask

  task automatic test_clean_press();
    int p0;
    sw_data = 4'hA; sw_err = 7'h04;
    repeat (3) tick();
    p0 = dut_presses;
    btn_raw = 1;
    repeat (20) tick();
    n_checks++;
    if (dut_presses - p0 != 1) begin n_fail++; $display("FAIL clean_press_count got=%0d exp=1", dut_presses - p0); end
    n_checks++;
    if (data_q !== 4'hA) begin n_fail++; $display("FAIL clean_data_q got=%h exp=a", data_q); end
    n_checks++;
    if (err_q !== 7'h04) begin n_fail++; $display("FAIL clean_err_q got=%h exp=04", err_q); end
    n_checks++;
    if (valid !== 1'b1 || btn_level !== 1'b1) begin n_fail++; $display("FAIL clean_valid_level got=%b%b exp=11", valid, btn_level); end
  endtask

  task automatic test_hold_switch();
    sw_data = 4'h3;
    repeat (12) tick();
    n_checks++;
    if (data_q !== 4'hA) begin n_fail++; $display("FAIL hold_data_kept got=%h exp=a", data_q); end
    btn_raw = 0;
    repeat (S + D + 6) tick();
    btn_raw = 1;
    repeat (S + D + 6) tick();
    n_checks++;
    if (data_q !== 4'h3) begin n_fail++; $display("FAIL hold_next_latch got=%h exp=3", data_q); end
    btn_raw = 0;
    repeat (S + D + 6) tick();
  endtask

  task automatic test_bounce();
    int p0;
    int during;
    sw_data = 4'h6; sw_err = 7'h3C;
    p0 = dut_presses;
    for (int i = 0; i < 30; i++) begin
      btn_raw = ((i / 3) % 2 == 0);
      tick();
    end
    during = dut_presses - p0;
    btn_raw = 1;
    repeat (20) tick();
    n_checks++;
    if (during != 0) begin n_fail++; $display("FAIL bounce_early_press got=%0d exp=0", during); end
    n_checks++;
    if (dut_presses - p0 != 1) begin n_fail++; $display("FAIL bounce_press_count got=%0d exp=1", dut_presses - p0); end
    n_checks++;
    if (data_q !== 4'h6 || err_q !== 7'h3C) begin n_fail++; $display("FAIL bounce_latch got=%h/%h exp=6/3c", data_q, err_q); end
  endtask

  task automatic test_release_glitch();
    int p0;
    bit dropped;
    p0 = dut_presses; dropped = 0;
    btn_raw = 0;
    repeat (4) begin tick(); if (btn_level !== 1'b1) dropped = 1; end
    btn_raw = 1;
    repeat (20) begin tick(); if (btn_level !== 1'b1) dropped = 1; end
    n_checks++;
    if (dropped) begin n_fail++; $display("FAIL glitch_level got=dropped exp=held 1"); end
    n_checks++;
    if (dut_presses - p0 != 0) begin n_fail++; $display("FAIL glitch_extra_press got=%0d exp=0", dut_presses - p0); end
    btn_raw = 0;
    repeat (S + D + 6) tick();
  endtask

  task automatic test_random();
    int p0;
    p0 = dut_presses;
    for (int seg = 0; seg < 60; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      sw_data = 4'($urandom);
      sw_err  = 7'($urandom);
      repeat ($urandom_range(1, 14)) tick();
    end
    btn_raw = 0;
    repeat (S + D + 6) tick();
    n_checks++;
    if (btn_level !== 1'b0) begin n_fail++; $display("FAIL random_settle_level got=%b exp=0", btn_level); end
  endtask

  task automatic test_mid_reset();
    int p0;
    rst_n = 0; btn_raw = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_cleared got=%b exp=0", valid); end
    p0 = dut_presses;
    btn_raw = 1;
    repeat (S + 4) tick();
    rst_n = 0;
    tick();
    rst_n = 1; btn_raw = 0;
    repeat (S + D + 6) tick();
    n_checks++;
    if (dut_presses - p0 != 0) begin n_fail++; $display("FAIL midrst_press got=%0d exp=0", dut_presses - p0); end
    n_checks++;
    if (valid !== 1'b0 || btn_level !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_level got=%b%b exp=00", valid, btn_level); end
  endtask

  initial begin
    for (int i = 0; i < S; i++) begin m_sd[i] = '0; m_se[i] = '0; end
    test_reset();
    test_clean_press();
    test_hold_switch();
    test_bounce();
    test_release_glitch();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at t=%0t exp=finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
